// File: rtl/if_fetch_predict_stage_pkg.sv
// Shared pipeline types and constants for the fetch/predict stage:
// counter encodings, BTB entry layout and the IF/ID payload.
package if_fetch_predict_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned WADDR_W = XLEN - 2;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag is held zero-extended to a full word address so the layout is size-independent.
  typedef struct packed {
    logic               valid;
    logic [WADDR_W-1:0] tag;
    logic [WADDR_W-1:0] target;
    logic [1:0]         ctr;
  } btb_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } ifid_t;

  localparam ifid_t IFID_NOP = '{
    pc:          '0,
    instr:       NOP_INSTR,
    valid:       1'b0,
    pred_taken:  1'b0,
    pred_target: '0
  };

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_ST) res = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/if_fetch_predict_stage_btb_2bit.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Combinational lookup sees the pre-update entry when lookup and update collide.
module btb_2bit
  import if_fetch_predict_stage_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] i_lk_pc,
  output logic            o_hit_c,
  output logic            o_pred_taken_c,
  output logic [XLEN-1:0] o_target_c,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target
);

  localparam int unsigned IW = $clog2(ENTRIES);

  btb_entry_t r_entries [ENTRIES];

  logic [IW-1:0]      w_lk_idx;
  logic [IW-1:0]      w_upd_idx;
  logic [WADDR_W-1:0] w_lk_tag;
  logic [WADDR_W-1:0] w_upd_tag;
  logic [WADDR_W-1:0] w_upd_target;
  btb_entry_t         w_lk_entry;
  btb_entry_t         w_upd_entry;
  logic               w_upd_hit;

  assign w_lk_idx     = i_lk_pc[1+IW:2];
  assign w_lk_tag     = WADDR_W'(i_lk_pc >> (2 + IW));
  assign w_upd_idx    = i_upd_pc[1+IW:2];
  assign w_upd_tag    = WADDR_W'(i_upd_pc >> (2 + IW));
  assign w_upd_target = WADDR_W'(i_upd_target >> 2);

  assign w_lk_entry  = r_entries[w_lk_idx];
  assign w_upd_entry = r_entries[w_upd_idx];
  assign w_upd_hit   = w_upd_entry.valid && (w_upd_entry.tag == w_upd_tag);

  assign o_hit_c        = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);
  assign o_pred_taken_c = o_hit_c && w_lk_entry.ctr[1];
  assign o_target_c     = {w_lk_entry.target, 2'b00};

  // Resolved-branch training: strengthen/weaken on hit, allocate on taken miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_entries[IW'(i)] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (i_upd_valid) begin
      if (w_upd_hit) begin
        r_entries[w_upd_idx].ctr <= ctr_update(w_upd_entry.ctr, i_upd_taken);
        if (i_upd_taken) r_entries[w_upd_idx].target <= w_upd_target;
      end else if (i_upd_taken) begin
        r_entries[w_upd_idx] <= '{valid: 1'b1, tag: w_upd_tag, target: w_upd_target, ctr: CTR_WT};
      end
    end
  end

endmodule

// File: rtl/if_fetch_predict_stage.sv
// Instruction fetch with BTB-based next-PC prediction and the IF/ID register.
// Redirects from EX win over load-use holds; reset wins over both.
module if_fetch_predict_stage
  import if_fetch_predict_stage_pkg::*;
#(
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_gate,
  input  logic            wrong_prediction,
  input  logic [XLEN-1:0] correct_pc,
  input  logic            ex_branch_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [XLEN-1:0] IF_ID_instr,
  output logic [4:0]      IF_ID_rs1,
  output logic [4:0]      IF_ID_rs2,
  output logic            IF_ID_valid,
  output logic            IF_ID_pred_taken,
  output logic [XLEN-1:0] IF_ID_pred_target
);

  logic [XLEN-1:0] r_pc;
  ifid_t           r_ifid;

  logic            w_btb_hit;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_btb_target;
  logic [XLEN-1:0] w_next_pc;

  btb_2bit #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk            (clk),
    .reset          (reset),
    .i_lk_pc        (r_pc),
    .o_hit_c        (w_btb_hit),
    .o_pred_taken_c (w_pred_taken),
    .o_target_c     (w_btb_target),
    .i_upd_valid    (ex_branch_valid),
    .i_upd_pc       (ex_pc),
    .i_upd_taken    (ex_taken),
    .i_upd_target   (ex_target)
  );

  assign w_next_pc = w_pred_taken ? w_btb_target : r_pc + XLEN'(4);

  // PC and IF/ID advance together; a redirect always injects one bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= RESET_PC;
      r_ifid <= IFID_NOP;
    end else if (wrong_prediction) begin
      r_pc   <= correct_pc;
      r_ifid <= IFID_NOP;
    end else if (clk_gate) begin
      r_pc   <= w_next_pc;
      r_ifid <= '{
        pc:          r_pc,
        instr:       imem_rdata,
        valid:       1'b1,
        pred_taken:  w_pred_taken,
        pred_target: w_next_pc
      };
    end
  end

  assign imem_addr         = r_pc;
  assign IF_ID_pc          = r_ifid.pc;
  assign IF_ID_instr       = r_ifid.instr;
  assign IF_ID_rs1         = r_ifid.instr[19:15];
  assign IF_ID_rs2         = r_ifid.instr[24:20];
  assign IF_ID_valid       = r_ifid.valid;
  assign IF_ID_pred_taken  = r_ifid.pred_taken;
  assign IF_ID_pred_target = r_ifid.pred_target;

  // Hit is folded into pred_taken; kept as a named net for debug visibility.
  logic w_unused;
  assign w_unused = w_btb_hit;

endmodule
